// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with the 40-bit humidity/temperature frame.
// Optional macro DHT_CHECKSUM_INV_EN adds inv_checksum, which sends an inverted checksum.
module dht11_responder #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int START_MIN_US = 18000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
`ifdef DHT_CHECKSUM_INV_EN
  input  logic       inv_checksum,
`endif
  output logic       busy,
  output logic       frame_done
);

  localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int PS_W       = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  // Wide enough that the saturated start count always exceeds START_MIN_US.
  localparam int US_W       = ((START_MIN_US + 2) > 256) ? $clog2(START_MIN_US + 2) : 8;

  localparam logic [PS_W-1:0] PS_LAST     = PS_W'(CYC_PER_US - 1);
  localparam logic [US_W-1:0] START_MIN_C = US_W'(START_MIN_US);
  localparam logic [US_W-1:0] US_MAX      = {US_W{1'b1}};
  localparam logic [US_W-1:0] T_RESP_US   = US_W'(30);
  localparam logic [US_W-1:0] T_ACK_US    = US_W'(80);
  localparam logic [US_W-1:0] T_BITLOW_US = US_W'(50);
  localparam logic [US_W-1:0] T_ONE_US    = US_W'(70);
  localparam logic [US_W-1:0] T_ZERO_US   = US_W'(26);
  localparam logic [US_W-1:0] T_END_US    = US_W'(50);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_DET = 3'd1,
    RESP_WAIT = 3'd2,
    ACK_LOW   = 3'd3,
    ACK_HIGH  = 3'd4,
    BIT_LOW   = 3'd5,
    BIT_HIGH  = 3'd6,
    END_LOW   = 3'd7
  } state_t;

  function automatic logic [7:0] dht_checksum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic [PS_W-1:0]   ps_q, ps_d, ps_inc_s;
  logic [US_W-1:0]   us_q, us_d, us_inc_s, phase_len_s;
  logic [5:0]        bit_q, bit_d;
  logic [39:0]       shreg_q, shreg_d;
  logic              dht_oe_q, dht_oe_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              line_s, us_tick_s, phase_end_s;
  logic [7:0]        sum_s, csum_s;

  assign line_s    = sync_q[1];
  assign us_tick_s = (ps_q == PS_LAST);
  assign sum_s     = dht_checksum(hum_int, hum_dec, temp_int, temp_dec);
`ifdef DHT_CHECKSUM_INV_EN
  assign csum_s    = inv_checksum ? ~sum_s : sum_s;
`else
  assign csum_s    = sum_s;
`endif

  // Length of the current timed phase in microseconds.
  always_comb begin
    phase_len_s = US_W'(1);
    case (state_q)
      RESP_WAIT: phase_len_s = T_RESP_US;
      ACK_LOW:   phase_len_s = T_ACK_US;
      ACK_HIGH:  phase_len_s = T_ACK_US;
      BIT_LOW:   phase_len_s = T_BITLOW_US;
      BIT_HIGH:  phase_len_s = shreg_q[39] ? T_ONE_US : T_ZERO_US;
      END_LOW:   phase_len_s = T_END_US;
      default:   phase_len_s = US_W'(1);
    endcase
  end

  assign phase_end_s = us_tick_s && (us_q == (phase_len_s - US_W'(1)));

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;
    ps_inc_s     = us_tick_s ? {PS_W{1'b0}} : (ps_q + PS_W'(1));
    us_inc_s     = (us_tick_s && (us_q != US_MAX)) ? (us_q + US_W'(1)) : us_q;
    ps_d         = ps_inc_s;
    us_d         = us_inc_s;

    case (state_q)
      IDLE: begin
        if (!line_s) state_d = START_DET;
        else         state_d = IDLE;
      end
      START_DET: begin
        if (line_s) begin
          if (us_q >= START_MIN_C) begin
            state_d = RESP_WAIT;
            shreg_d = {hum_int, hum_dec, temp_int, temp_dec, csum_s};
            bit_d   = 6'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = START_DET;
        end
      end
      RESP_WAIT: begin
        if (phase_end_s) state_d = ACK_LOW;
        else             state_d = RESP_WAIT;
      end
      ACK_LOW: begin
        if (phase_end_s) state_d = ACK_HIGH;
        else             state_d = ACK_LOW;
      end
      ACK_HIGH: begin
        if (phase_end_s) state_d = BIT_LOW;
        else             state_d = ACK_HIGH;
      end
      BIT_LOW: begin
        if (phase_end_s) state_d = BIT_HIGH;
        else             state_d = BIT_LOW;
      end
      BIT_HIGH: begin
        if (phase_end_s) begin
          if (bit_q == 6'd39) begin
            state_d = END_LOW;
          end else begin
            state_d = BIT_LOW;
            bit_d   = bit_q + 6'd1;
            shreg_d = {shreg_q[38:0], 1'b0};
          end
        end else begin
          state_d = BIT_HIGH;
        end
      end
      END_LOW: begin
        if (phase_end_s) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d      = END_LOW;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry restarts the microsecond timebase.
    if (state_d != state_q) begin
      ps_d = {PS_W{1'b0}};
      us_d = {US_W{1'b0}};
    end else begin
      ps_d = ps_inc_s;
      us_d = us_inc_s;
    end

    dht_oe_d = (state_d == ACK_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
    busy_d   = (state_d != IDLE) && (state_d != START_DET);
  end

  // State, synchronizer, counters and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sync_q       <= 2'b00;
      ps_q         <= {PS_W{1'b0}};
      us_q         <= {US_W{1'b0}};
      bit_q        <= 6'd0;
      shreg_q      <= 40'd0;
      dht_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], dht_in};
      ps_q         <= ps_d;
      us_q         <= us_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      dht_oe_q     <= dht_oe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dht_oe     = dht_oe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host start pulses, open-drain line model, frame waveform reference.
// Runs at 2 MHz so the prescaler is exercised while the frames stay short in cycles.
module tb_dht11_responder;

  localparam int CLK_HZ   = 2_000_000;
  localparam int CPU      = CLK_HZ / 1_000_000;
  localparam int START_US = 1000;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] hum_int  = 8'h00;
  logic [7:0] hum_dec  = 8'h00;
  logic [7:0] temp_int = 8'h00;
  logic [7:0] temp_dec = 8'h00;
`ifdef DHT_CHECKSUM_INV_EN
  logic       inv_checksum = 1'b0;
`endif
  logic       dht_oe, busy, frame_done;
  wire        dht_in;

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];
  int seg_q[$];
  int exp_ck;
  int lead, fd_pulses;
  bit cap_ok;
  logic done_oe, done_busy;

  always #5 clock = ~clock;

  // Open-drain line: low when either the host or the responder pulls it.
  assign dht_in = ~(host_low | dht_oe);

  dht11_responder #(.CLK_FREQ_HZ(CLK_HZ), .START_MIN_US(START_US)) dut (
    .clock(clock), .reset_n(reset_n), .dht_in(dht_in), .dht_oe(dht_oe),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
`ifdef DHT_CHECKSUM_INV_EN
    .inv_checksum(inv_checksum),
`endif
    .busy(busy), .frame_done(frame_done)
  );

  // Reference: expected dht_oe run lengths in cycles, starting at the ACK low.
  task automatic build_expected(input int b0, input int b1, input int b2, input int b3, input bit inv);
    int bytes [5];
    exp_ck = (b0 + b1 + b2 + b3) % 256;
    if (inv) exp_ck = 255 - exp_ck;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3; bytes[4] = exp_ck;
    exp_q.delete();
    exp_q.push_back(80 * CPU);
    exp_q.push_back(80 * CPU);
    for (int i = 0; i < 40; i++) begin
      int bitv;
      bitv = (bytes[i / 8] >> (7 - (i % 8))) & 1;
      exp_q.push_back(50 * CPU);
      exp_q.push_back((bitv == 1) ? 70 * CPU : 26 * CPU);
    end
    exp_q.push_back(50 * CPU);
  endtask

  task automatic host_start(input int low_us);
    @(negedge clock);
    host_low = 1'b1;
    repeat (low_us * CPU) @(negedge clock);
    host_low = 1'b0;
  endtask

  task automatic capture_frame(input bit do_change, input logic [7:0] new_hum);
    int n, run;
    logic prev;
    bit changed;
    seg_q.delete();
    lead = -1; fd_pulses = 0; cap_ok = 0; changed = 0;
    done_oe = 1'bx; done_busy = 1'bx;
    n = 0;
    while (busy !== 1'b1 && n < 20000) begin @(negedge clock); n++; end
    if (busy !== 1'b1) return;
    lead = 0;
    while (dht_oe !== 1'b1 && lead < 2000) begin @(negedge clock); lead++; end
    prev = 1'b1; run = 1; n = 0;
    while (n < 40000) begin
      @(negedge clock); n++;
      if (frame_done === 1'b1) fd_pulses++;
      if (dht_oe === prev) begin
        run++;
      end else begin
        seg_q.push_back(run);
        prev = dht_oe; run = 1;
        if (do_change && !changed) begin hum_int = new_hum; changed = 1; end
      end
      if (frame_done === 1'b1) begin
        cap_ok = 1; done_oe = dht_oe; done_busy = busy;
        break;
      end
    end
    repeat (20) begin
      @(negedge clock);
      if (frame_done === 1'b1) fd_pulses++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clock);
    vectors++;
    if ({dht_oe, busy, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got oe/busy/done=%b required 000", {dht_oe, busy, frame_done});
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    vectors++;
    if ({dht_oe, busy, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: got oe/busy/done=%b required 000", {dht_oe, busy, frame_done});
    end
  endtask

  task automatic test_short_start();
    int oe_seen, busy_seen, fd_seen;
    oe_seen = 0; busy_seen = 0; fd_seen = 0;
    host_start(500);
    repeat (3000) begin
      @(negedge clock);
      if (dht_oe === 1'b1) oe_seen++;
      if (busy === 1'b1) busy_seen++;
      if (frame_done === 1'b1) fd_seen++;
    end
    vectors++;
    if (oe_seen != 0) begin errors++; $display("FAIL short_start_oe: got %0d low cycles required 0", oe_seen); end
    vectors++;
    if (busy_seen != 0) begin errors++; $display("FAIL short_start_busy: got %0d busy cycles required 0", busy_seen); end
    vectors++;
    if (fd_seen != 0) begin errors++; $display("FAIL short_start_done: got %0d pulses required 0", fd_seen); end
  endtask

  task automatic test_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input bit inv,
                            input bit do_change, input logic [7:0] new_hum);
    int got_ck;
    hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
`ifdef DHT_CHECKSUM_INV_EN
    inv_checksum = inv;
`endif
    build_expected(int'(a), int'(b), int'(c), int'(d), inv);
    repeat (20) @(negedge clock);
    host_start(1200);
    capture_frame(do_change, new_hum);
    vectors++;
    if (cap_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_complete: got frame_done seen=%0d required 1 (timeout)", name, cap_ok);
    end
    vectors++;
    if (lead != 30 * CPU) begin
      errors++;
      $display("FAIL %s_resp_wait: got %0d cycles required %0d", name, lead, 30 * CPU);
    end
    vectors++;
    if (seg_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_segments: got %0d segments required %0d", name, seg_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (seg_q[i] != exp_q[i]) begin
          errors++;
          $display("FAIL %s_seg%0d: got %0d cycles required %0d", name, i, seg_q[i], exp_q[i]);
        end
      end
      got_ck = 0;
      for (int i = 32; i < 40; i++) got_ck = (got_ck << 1) | ((seg_q[3 + 2 * i] > 48 * CPU) ? 1 : 0);
      vectors++;
      if (got_ck != exp_ck) begin
        errors++;
        $display("FAIL %s_checksum: got 0x%02h required 0x%02h", name, got_ck, exp_ck);
      end
    end
    vectors++;
    if ({done_oe, done_busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s_release: got oe/busy=%b at frame_done required 00", name, {done_oe, done_busy});
    end
    vectors++;
    if (fd_pulses != 1) begin
      errors++;
      $display("FAIL %s_done_pulses: got %0d required 1", name, fd_pulses);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rises, n;
    logic prev;
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    repeat (20) @(negedge clock);
    host_start(1200);
    rises = 0; n = 0; prev = dht_oe;
    // ACK low is the first rise, so bit 12's low phase is the fourteenth.
    while (rises < 14 && n < 30000) begin
      @(negedge clock); n++;
      if (dht_oe === 1'b1 && prev !== 1'b1) rises++;
      prev = dht_oe;
    end
    vectors++;
    if (rises != 14) begin errors++; $display("FAIL midreset_reach_bit12: got %0d rises required 14", rises); end
    repeat (10 * CPU) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    vectors++;
    if ({dht_oe, busy, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_release: got oe/busy/done=%b required 000", {dht_oe, busy, frame_done});
    end
    n = 0;
    repeat (5) begin @(negedge clock); if (frame_done === 1'b1) n++; end
    reset_n = 1'b1;
    repeat (200) begin @(negedge clock); if (frame_done === 1'b1 || dht_oe === 1'b1) n++; end
    vectors++;
    if (n != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles required 0", n); end
    test_frame("after_reset", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    test_reset();
    test_short_start();
    test_frame("basic", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 1'b0, 8'h00);
    test_frame("wrap", 8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b0, 1'b0, 8'h00);
    test_frame("latch", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 1'b1, 8'h99);
    test_reset_mid_frame();
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    test_frame("random", r0, r1, r2, r3, 1'b0, 1'b0, 8'h00);
`ifdef DHT_CHECKSUM_INV_EN
    test_frame("inv_ck", 8'h37, 8'h00, 8'h19, 8'h00, 1'b1, 1'b0, 8'h00);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
